// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the memory stage (master) and data memory (slave).
// Ready-handshaked: a request is held until mem_ready is seen high.
interface mem_stage_lsu_if #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
);
    localparam int unsigned LANES = DATA_WIDTH / 8;

    logic                     mem_req;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic [LANES-1:0]         mem_wstrb;
    logic                     mem_ready;
    logic [DATA_WIDTH-1:0]    mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory stage: registers execute results, runs one data-memory access, aligns/extends loads.
// Optional bus watchdog enabled by defining MEM_STAGE_TIMEOUT_EN.
module mem_stage_lsu #(
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_e,
    input  logic                     reg_write_e,
    input  logic                     mem_write_e,
    input  logic                     mem_read_e,
    input  logic [1:0]               result_src_e,
    input  logic [2:0]               funct3_e,
    input  logic [DATA_WIDTH-1:0]    alu_result_e,
    input  logic [DATA_WIDTH-1:0]    write_data_e,
    input  logic [4:0]               rd_e,
    input  logic [ADDRESS_WIDTH-1:0] pc_plus4_e,
    output logic                     stall_m,
    mem_stage_lsu_if.master          mem_bus,
    output logic                     valid_m,
    output logic                     reg_write_m,
    output logic [1:0]               result_src_m,
    output logic [DATA_WIDTH-1:0]    alu_result_m,
    output logic [DATA_WIDTH-1:0]    read_data_m,
    output logic [4:0]               rd_m,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_m,
    output logic                     misalign_m,
    output logic                     bus_err_m
);
    localparam int unsigned LANES = DATA_WIDTH / 8;
    localparam int unsigned OFS   = $clog2(LANES);

    typedef enum logic [1:0] {StEmpty, StPass, StWait} state_e;

    state_e                   state_q, state_d;
    logic                     s_reg_write_q, s_mem_write_q, s_mem_read_q, s_misalign_q;
    logic [1:0]               s_result_src_q;
    logic [2:0]               s_funct3_q;
    logic [DATA_WIDTH-1:0]    s_alu_result_q, s_write_data_q;
    logic [4:0]               s_rd_q;
    logic [ADDRESS_WIDTH-1:0] s_pc_plus4_q;

    logic e_mem, e_illegal, e_bad_align, e_misalign;
    logic load, abort, in_wait;

    // Illegal sizes (111 always, 011/110 on a 32-bit datapath) take the misaligned path.
    always_comb begin
        e_mem       = mem_read_e | mem_write_e;
        e_illegal   = (funct3_e == 3'b111) ||
                      ((DATA_WIDTH == 32) && (funct3_e == 3'b011 || funct3_e == 3'b110));
        e_bad_align = 1'b0;
        case (funct3_e[1:0])
            2'b01:   e_bad_align = alu_result_e[0];
            2'b10:   e_bad_align = |alu_result_e[1:0];
            2'b11:   e_bad_align = |alu_result_e[2:0];
            default: e_bad_align = 1'b0;
        endcase
        e_misalign = e_mem & (e_illegal | e_bad_align);
    end

    always_comb begin
        in_wait = (state_q == StWait);
        stall_m = in_wait & ~mem_bus.mem_ready & ~abort;
        load    = ~stall_m;
        state_d = state_q;
        if (load) begin
            if (!valid_e)                 state_d = StEmpty;
            else if (e_mem & ~e_misalign) state_d = StWait;
            else                          state_d = StPass;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StEmpty;
            s_reg_write_q  <= 1'b0;
            s_mem_write_q  <= 1'b0;
            s_mem_read_q   <= 1'b0;
            s_misalign_q   <= 1'b0;
            s_result_src_q <= '0;
            s_funct3_q     <= '0;
            s_alu_result_q <= '0;
            s_write_data_q <= '0;
            s_rd_q         <= '0;
            s_pc_plus4_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                s_reg_write_q  <= reg_write_e;
                s_mem_write_q  <= mem_write_e;
                s_mem_read_q   <= mem_read_e;
                s_misalign_q   <= e_misalign;
                s_result_src_q <= result_src_e;
                s_funct3_q     <= funct3_e;
                s_alu_result_q <= alu_result_e;
                s_write_data_q <= write_data_e;
                s_rd_q         <= rd_e;
                s_pc_plus4_q   <= pc_plus4_e;
            end
        end
    end

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;

    assign abort = in_wait & ~mem_bus.mem_ready & (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (load && state_d == StWait)      wd_cnt_d = '0;
        else if (in_wait & ~mem_bus.mem_ready) wd_cnt_d = wd_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wd_cnt_q <= '0;
        else        wd_cnt_q <= wd_cnt_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign abort = 1'b0;
`endif

    logic [ADDRESS_WIDTH-1:0] addr_full;
    logic [OFS+2:0]           rshift;
    logic [63:0]              wd64, wrep64, rd64, ld64;
    logic [7:0]               size_mask, strb8;
    logic                     sgn;

    always_comb begin
        addr_full = ADDRESS_WIDTH'(s_alu_result_q);
        wd64      = 64'(s_write_data_q);
        case (s_funct3_q[1:0])
            2'b00:   begin wrep64 = {8{wd64[7:0]}};  size_mask = 8'h01; end
            2'b01:   begin wrep64 = {4{wd64[15:0]}}; size_mask = 8'h03; end
            2'b10:   begin wrep64 = {2{wd64[31:0]}}; size_mask = 8'h0f; end
            default: begin wrep64 = wd64;            size_mask = 8'hff; end
        endcase
        strb8 = size_mask << s_alu_result_q[OFS-1:0];

        rshift = {s_alu_result_q[OFS-1:0], 3'b000};
        rd64   = 64'(mem_bus.mem_rdata) >> rshift;
        sgn    = ~s_funct3_q[2];
        case (s_funct3_q[1:0])
            2'b00:   ld64 = {{56{sgn & rd64[7]}},  rd64[7:0]};
            2'b01:   ld64 = {{48{sgn & rd64[15]}}, rd64[15:0]};
            2'b10:   ld64 = {{32{sgn & rd64[31]}}, rd64[31:0]};
            default: ld64 = rd64;
        endcase

        mem_bus.mem_req   = in_wait;
        mem_bus.mem_we    = s_mem_write_q;
        mem_bus.mem_addr  = addr_full & ~ADDRESS_WIDTH'(LANES - 1);
        mem_bus.mem_wdata = wrep64[DATA_WIDTH-1:0];
        mem_bus.mem_wstrb = s_mem_write_q ? strb8[LANES-1:0] : '0;

        valid_m      = (state_q == StPass) | (in_wait & (mem_bus.mem_ready | abort));
        reg_write_m  = valid_m & s_reg_write_q & ~s_misalign_q & ~abort;
        misalign_m   = valid_m & s_misalign_q;
        bus_err_m    = abort;
        result_src_m = s_result_src_q;
        alu_result_m = s_alu_result_q;
        rd_m         = s_rd_q;
        pc_plus4_m   = s_pc_plus4_q;
        read_data_m  = (in_wait & s_mem_read_q) ? ld64[DATA_WIDTH-1:0] : '0;
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed ops push expected results, a monitor checks them.
module tb_mem_stage_lsu;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          valid_e, reg_write_e, mem_write_e, mem_read_e;
    logic [1:0]    result_src_e;
    logic [2:0]    funct3_e;
    logic [DW-1:0] alu_result_e, write_data_e;
    logic [4:0]    rd_e;
    logic [AW-1:0] pc_plus4_e;
    logic          stall_m, valid_m, reg_write_m, misalign_m, bus_err_m;
    logic [1:0]    result_src_m;
    logic [DW-1:0] alu_result_m, read_data_m;
    logic [4:0]    rd_m;
    logic [AW-1:0] pc_plus4_m;

    mem_stage_lsu_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) mem_bus ();

    mem_stage_lsu #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_e      (valid_e),
        .reg_write_e  (reg_write_e),
        .mem_write_e  (mem_write_e),
        .mem_read_e   (mem_read_e),
        .result_src_e (result_src_e),
        .funct3_e     (funct3_e),
        .alu_result_e (alu_result_e),
        .write_data_e (write_data_e),
        .rd_e         (rd_e),
        .pc_plus4_e   (pc_plus4_e),
        .stall_m      (stall_m),
        .mem_bus      (mem_bus),
        .valid_m      (valid_m),
        .reg_write_m  (reg_write_m),
        .result_src_m (result_src_m),
        .alu_result_m (alu_result_m),
        .read_data_m  (read_data_m),
        .rd_m         (rd_m),
        .pc_plus4_m   (pc_plus4_m),
        .misalign_m   (misalign_m),
        .bus_err_m    (bus_err_m)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        rw;
        logic        mis;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] resp_q[$];
    int          resp_lat = 0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          req_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory responder: ready after resp_lat cycles of a request; data from resp_q.
    initial begin
        logic [31:0] cur;
        int          cnt;
        bit          active;
        cur = '0; cnt = 0; active = 1'b0;
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!mem_bus.mem_req) begin
                active = 1'b0;
                mem_bus.mem_ready = 1'b0;
                mem_bus.mem_rdata = '0;
            end else begin
                if (!active || mem_bus.mem_ready) begin
                    active = 1'b1;
                    cnt = 0;
                    cur = (resp_q.size() != 0) ? resp_q.pop_front() : 32'h0;
                end else begin
                    cnt++;
                end
                mem_bus.mem_ready = (cnt == resp_lat);
                mem_bus.mem_rdata = mem_bus.mem_ready ? cur : 32'h0;
            end
        end
    end

    // Monitor: every valid_m pops one expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_bus.mem_req) req_seen++;
            if (rst_n && valid_m) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_valid_m", valid_m, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    chk("valid_cycle", cyc, e.cyc);
                    chk("rd_m", rd_m, e.rd);
                    chk("alu_result_m", alu_result_m, e.alu);
                    chk("pc_plus4_m", pc_plus4_m, e.alu + 32'd4);
                    chk("read_data_m", read_data_m, e.rdata);
                    chk("reg_write_m", reg_write_m, e.rw);
                    chk("misalign_m", misalign_m, e.mis);
                    chk("bus_err_m", bus_err_m, e.err);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the op is accepted.
    task automatic send(input logic rw, input logic mw, input logic mr, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                        input logic [31:0] exp_rdata, input logic exp_rw, input logic exp_mis,
                        input logic exp_err, input int lat, input bit push);
        exp_t e;
        int   guard;
        valid_e = 1'b1; reg_write_e = rw; mem_write_e = mw; mem_read_e = mr;
        result_src_e = 2'b01; funct3_e = f3; alu_result_e = alu; write_data_e = wd;
        rd_e = rd; pc_plus4_e = alu + 32'd4;
        guard = 0;
        while (stall_m && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("accept_timeout", stall_m, 1'b0);
        if (push) begin
            e.rd = rd; e.alu = alu; e.rdata = exp_rdata; e.rw = exp_rw;
            e.mis = exp_mis; e.err = exp_err; e.cyc = cyc + 1 + lat;
            sb_q.push_back(e);
        end
        @(negedge clk);
        valid_e = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_e = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int st, r0, err_seen;
        valid_e = 0; reg_write_e = 0; mem_write_e = 0; mem_read_e = 0; result_src_e = 0;
        funct3_e = 0; alu_result_e = 0; write_data_e = 0; rd_e = 0; pc_plus4_e = 0;
        repeat (2) @(negedge clk);
        chk("rst_stall_m", stall_m, 0);
        chk("rst_mem_req", mem_bus.mem_req, 0);
        chk("rst_valid_m", valid_m, 0);
        chk("rst_ctrl", {reg_write_m, misalign_m, bus_err_m}, 0);
        chk("rst_alu_result_m", alu_result_m, 0);
        chk("rst_read_data_m", read_data_m, 0);
        chk("rst_rd_pc", {rd_m, pc_plus4_m}, 0);
        chk("rst_bus_data", {mem_bus.mem_addr, mem_bus.mem_wdata, mem_bus.mem_wstrb}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        send(1, 0, 0, 3'b000, 32'h1234, 0, 5, 0, 1, 0, 0, 0, 1);
        idle(2);
        chk("add_no_req", req_seen, 0);

        send(1, 0, 1, 3'b010, 32'h101, 0, 6, 0, 0, 1, 0, 0, 1);
        idle(2);
        chk("misalign_no_req", req_seen, 0);

        resp_lat = 0;
        send(0, 1, 0, 3'b000, 32'h103, 32'hAB, 0, 0, 0, 0, 0, 0, 1);
        chk("sb_addr", mem_bus.mem_addr, 32'h100);
        chk("sb_wstrb", mem_bus.mem_wstrb, 4'b1000);
        chk("sb_wdata", mem_bus.mem_wdata, 32'hABAB_ABAB);
        chk("sb_we", mem_bus.mem_we, 1);
        chk("sb_stall", stall_m, 0);
        idle(1);

        send(0, 1, 0, 3'b001, 32'h102, 32'h1234, 0, 0, 0, 0, 0, 0, 1);
        chk("sh_wstrb", mem_bus.mem_wstrb, 4'b1100);
        chk("sh_wdata", mem_bus.mem_wdata, 32'h1234_1234);
        idle(1);

        resp_lat = 3;
        resp_q.push_back(32'h0080_0000);
        send(1, 0, 1, 3'b000, 32'h102, 0, 7, 32'hFFFF_FF80, 1, 0, 0, 3, 1);
        chk("lb_addr", mem_bus.mem_addr, 32'h100);
        chk("lb_we", mem_bus.mem_we, 0);
        st = 0;
        for (int i = 0; i < 4; i++) begin
            if (stall_m) st++;
            if (i < 3) @(negedge clk);
        end
        chk("lb_stall_cycles", st, 3);
        idle(1);

        resp_q.push_back(32'h0080_0000);
        send(1, 0, 1, 3'b100, 32'h102, 0, 7, 32'h0000_0080, 1, 0, 0, 3, 1);
        idle(5);

        resp_lat = 1;
        resp_q.push_back(32'h8001_0000);
        send(1, 0, 1, 3'b001, 32'h102, 0, 3, 32'hFFFF_8001, 1, 0, 0, 1, 1);
        resp_q.push_back(32'h8001_0000);
        send(1, 0, 1, 3'b101, 32'h102, 0, 4, 32'h0000_8001, 1, 0, 0, 1, 1);
        idle(3);

        r0 = req_seen;
        send(1, 0, 1, 3'b111, 32'h100, 0, 2, 0, 0, 1, 0, 0, 1);
        idle(2);
        chk("illegal_no_req", req_seen, r0);

        resp_lat = 0;
        resp_q.push_back(32'h1111_2222);
        resp_q.push_back(32'h3333_4444);
        send(1, 0, 1, 3'b010, 32'h200, 0, 8, 32'h1111_2222, 1, 0, 0, 0, 1);
        send(1, 0, 1, 3'b010, 32'h204, 0, 9, 32'h3333_4444, 1, 0, 0, 0, 1);
        send(1, 0, 0, 3'b000, 32'h55, 0, 10, 0, 1, 0, 0, 0, 1);
        idle(3);

        resp_lat = 1000;
`ifdef MEM_STAGE_TIMEOUT_EN
        send(1, 0, 1, 3'b010, 32'h300, 0, 11, 0, 0, 0, 1, TO - 1, 1);
        repeat (TO - 1) @(negedge clk);
        chk("wd_bus_err", bus_err_m, 1);
        chk("wd_stall_released", stall_m, 0);
        idle(2);
`else
        send(1, 0, 1, 3'b010, 32'h300, 0, 11, 0, 0, 0, 0, 0, 0);
        st = 0;
        err_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (stall_m) st++;
            if (bus_err_m) err_seen++;
            @(negedge clk);
        end
        chk("hang_stall_cycles", st, 20);
        chk("hang_no_bus_err", err_seen, 0);
`endif

        if (!stall_m) send(1, 0, 1, 3'b010, 32'h400, 0, 12, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_req", mem_bus.mem_req, 0);
        chk("rst_mid_stall", stall_m, 0);
        chk("rst_mid_valid", valid_m, 0);
        chk("rst_mid_alu", alu_result_m, 0);
        @(negedge clk);
        rst_n = 1'b1;
        resp_q.delete();
        resp_lat = 0;
        @(negedge clk);

        send(1, 0, 0, 3'b000, 32'h77, 0, 13, 0, 1, 0, 0, 0, 1);
        idle(3);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
